// File: rtl/mw_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// mw_wb_stage_pkg
// Shared pipeline package: write-back source and load-type encodings plus the
// reset PC. The D/E/M stages import the same definitions so every stage
// agrees on the control-field encodings carried down the pipe.
// ---------------------------------------------------------------------------
package mw_wb_stage_pkg;

    // PC loaded into the W-stage PC register on reset.
    localparam logic [31:0] PKG_RESET_PC = 32'h0000_3000;

    // Write-back source select. WB_RSVD behaves like WB_ALU.
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC8  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    // Load type. Codes 5-7 are unused and behave like LD_LW.
    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } ld_type_e;

endpackage : mw_wb_stage_pkg

// File: rtl/mw_wb_stage_load_ext.sv
// ---------------------------------------------------------------------------
// load_ext
// Purely combinational load extender. Selects the byte/half/word addressed by
// the low address bits out of an aligned memory word, sign- or zero-extends
// it, and reports whether the access was misaligned for its width.
//
// Ports
//   word     in  32  raw aligned data-memory word
//   offset   in   2  byte offset within the word (address bits [1:0])
//   ld_type  in   3  load type (ld_type_e; 5-7 behave as lw)
//   data     out 32  extended load result
//   misalign out  1  lw with offset!=0, or lh/lhu with offset[0]=1
// ---------------------------------------------------------------------------
module load_ext
    import mw_wb_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  ld_type,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        data     = word;
        misalign = 1'b0;

        byte_sel = word[{offset, 3'b000} +: 8];
        // Halfword select uses offset[1] only; an odd offset is flagged below.
        half_sel = offset[1] ? word[31:16] : word[15:0];

        case (ld_type)
            LD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU: data = {24'h0, byte_sel};
            LD_LH: begin
                data     = {{16{half_sel[15]}}, half_sel};
                misalign = offset[0];
            end
            LD_LHU: begin
                data     = {16'h0, half_sel};
                misalign = offset[0];
            end
            default: begin
                data     = word;
                misalign = (offset != 2'b00);
            end
        endcase
    end

endmodule : load_ext

// File: rtl/mw_wb_stage.sv
// ---------------------------------------------------------------------------
// mw_wb_stage
// M->W pipeline register plus write-back data path. Captures the M-stage slot
// every cycle (no stall), forms the register-file write from the W registers
// combinationally, suppresses misaligned loads and counts retired
// instructions.
//
// Ports
//   clk        in   1  clock, all state updates on posedge
//   reset      in   1  asynchronous, active-high reset
//   valid_m    in   1  M slot holds a real instruction
//   pc_m       in  32  PC of the M instruction
//   alu_m      in  32  ALU result; [1:0] is the load byte offset
//   dm_rdata_m in  32  raw aligned data-memory word
//   rf_we_m    in   1  instruction writes a GPR
//   a3_m       in   5  destination GPR index
//   wb_sel_m   in   2  write-back source (wb_sel_e)
//   ld_type_m  in   3  load type (ld_type_e)
//   rf_we      out  1  register-file write enable
//   rf_a3      out  5  register-file write index
//   rf_wd      out 32  register-file write data
//   wpc        out 32  PC of the W instruction
//   fwd_valid  out  1  rf_wd forwardable (rf_we=1 and rf_a3!=0)
//   misalign   out  1  W load misaligned, write suppressed
//   retired    out 32  valid instructions that have left W (wraps)
// ---------------------------------------------------------------------------
module mw_wb_stage
    import mw_wb_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PKG_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_m,
    input  logic [31:0] pc_m,
    input  logic [31:0] alu_m,
    input  logic [31:0] dm_rdata_m,
    input  logic        rf_we_m,
    input  logic [4:0]  a3_m,
    input  logic [1:0]  wb_sel_m,
    input  logic [2:0]  ld_type_m,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic [31:0] wpc,
    output logic        fwd_valid,
    output logic        misalign,
    output logic [31:0] retired
);

    // W-stage registers.
    logic        valid_q,   valid_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] alu_q,     alu_d;
    logic [31:0] rdata_q,   rdata_d;
    logic        rf_we_q,   rf_we_d;
    logic [4:0]  a3_q,      a3_d;
    logic [1:0]  wb_sel_q,  wb_sel_d;
    logic [2:0]  ld_type_q, ld_type_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] ld_data;
    logic        ld_misalign;

    // Next-state: unconditional capture of the M slot; the counter advances
    // for the instruction currently leaving W.
    always_comb begin
        valid_d   = valid_m;
        pc_d      = pc_m;
        alu_d     = alu_m;
        rdata_d   = dm_rdata_m;
        rf_we_d   = rf_we_m;
        a3_d      = a3_m;
        wb_sel_d  = wb_sel_m;
        ld_type_d = ld_type_m;
        retired_d = retired_q + {31'h0, valid_q};
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= RESET_PC;
            alu_q     <= 32'h0;
            rdata_q   <= 32'h0;
            rf_we_q   <= 1'b0;
            a3_q      <= 5'h0;
            wb_sel_q  <= WB_ALU;
            ld_type_q <= LD_LW;
            retired_q <= 32'h0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            alu_q     <= alu_d;
            rdata_q   <= rdata_d;
            rf_we_q   <= rf_we_d;
            a3_q      <= a3_d;
            wb_sel_q  <= wb_sel_d;
            ld_type_q <= ld_type_d;
            retired_q <= retired_d;
        end
    end

    load_ext u_load_ext (
        .word     (rdata_q),
        .offset   (alu_q[1:0]),
        .ld_type  (ld_type_q),
        .data     (ld_data),
        .misalign (ld_misalign)
    );

    // Write-back mux and write qualification, all from W registers so the
    // data is stable for the whole cycle ahead of the RF write edge.
    always_comb begin
        case (wb_sel_q)
            WB_MEM:  rf_wd = ld_data;
            WB_PC8:  rf_wd = pc_q + 32'd8;
            default: rf_wd = alu_q;
        endcase

        // Only memory write-backs can be misaligned.
        misalign  = (wb_sel_q == WB_MEM) && ld_misalign;
        rf_we     = valid_q && rf_we_q && !misalign;
        // Index 0 still writes (the RF drops it) but is never forwarded.
        fwd_valid = rf_we && (a3_q != 5'd0);
    end

    assign rf_a3   = a3_q;
    assign wpc     = pc_q;
    assign retired = retired_q;

endmodule : mw_wb_stage

// File: tb/tb_mw_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mw_wb_stage
// Scoreboard bench for mw_wb_stage. The stimulus process drives one M slot per
// cycle and pushes the expected W outputs, computed by a behavioural model
// from the load/write-back rules, into a queue. A monitor pops one entry after
// each capture edge and compares every W output.
// ---------------------------------------------------------------------------
module tb_mw_wb_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] word;
        logic        we;
        logic [4:0]  a3;
        logic [1:0]  wb_sel;
        logic [2:0]  ld_type;
    } m_slot_t;

    typedef struct {
        logic        rf_we;
        logic [4:0]  rf_a3;
        logic [31:0] rf_wd;
        logic [31:0] wpc;
        logic        fwd_valid;
        logic        misalign;
        logic [31:0] retired;
    } w_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m;
    logic [31:0] pc_m;
    logic [31:0] alu_m;
    logic [31:0] dm_rdata_m;
    logic        rf_we_m;
    logic [4:0]  a3_m;
    logic [1:0]  wb_sel_m;
    logic [2:0]  ld_type_m;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] wpc;
    logic        fwd_valid;
    logic        misalign;
    logic [31:0] retired;

    int n_checks = 0;
    int n_pass   = 0;

    w_exp_t      sb[$];
    logic [31:0] model_retired = 32'h0;

    always #5 clk = ~clk;

    mw_wb_stage #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_m    (valid_m),
        .pc_m       (pc_m),
        .alu_m      (alu_m),
        .dm_rdata_m (dm_rdata_m),
        .rf_we_m    (rf_we_m),
        .a3_m       (a3_m),
        .wb_sel_m   (wb_sel_m),
        .ld_type_m  (ld_type_m),
        .rf_we      (rf_we),
        .rf_a3      (rf_a3),
        .rf_wd      (rf_wd),
        .wpc        (wpc),
        .fwd_valid  (fwd_valid),
        .misalign   (misalign),
        .retired    (retired)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                      name, actual, expected, $time);
    endtask

    // Reference model: extract the addressed field arithmetically and derive
    // the write qualification from the architectural rules.
    function automatic w_exp_t model(input m_slot_t m, input logic [31:0] ret);
        w_exp_t      e;
        int unsigned off;
        logic [31:0] field;
        logic        is_word;
        logic        is_half;
        off     = int'(m.alu % 4);
        is_half = (m.ld_type == 3) || (m.ld_type == 4);
        is_word = (m.ld_type == 0) || (m.ld_type >= 5);

        if (m.wb_sel == 2) begin
            e.rf_wd = m.pc + 32'd8;
        end else if (m.wb_sel == 1) begin
            if (m.ld_type == 1 || m.ld_type == 2) begin
                field = (m.word >> (8 * off)) & 32'hFF;
                e.rf_wd = (m.ld_type == 1 && field >= 32'd128) ? field + 32'hFFFF_FF00 : field;
            end else if (is_half) begin
                field = (m.word >> (16 * (off / 2))) & 32'hFFFF;
                e.rf_wd = (m.ld_type == 3 && field >= 32'd32768) ? field + 32'hFFFF_0000 : field;
            end else begin
                e.rf_wd = m.word;
            end
        end else begin
            e.rf_wd = m.alu;
        end

        e.misalign  = (m.wb_sel == 1) && ((is_word && off != 0) || (is_half && off % 2 == 1));
        e.rf_we     = m.valid && m.we && !e.misalign;
        e.rf_a3     = m.a3;
        e.wpc       = m.pc;
        e.fwd_valid = e.rf_we && (m.a3 != 0);
        e.retired   = ret;
        return e;
    endfunction

    // Drive one M slot at the falling edge and record its expected W view.
    task automatic issue(input m_slot_t m);
        @(negedge clk);
        valid_m    = m.valid;
        pc_m       = m.pc;
        alu_m      = m.alu;
        dm_rdata_m = m.word;
        rf_we_m    = m.we;
        a3_m       = m.a3;
        wb_sel_m   = m.wb_sel;
        ld_type_m  = m.ld_type;
        sb.push_back(model(m, model_retired));
        model_retired = model_retired + (m.valid ? 32'd1 : 32'd0);
    endtask

    function automatic m_slot_t mk(input logic v, input logic [31:0] pc,
                                   input logic [31:0] alu, input logic [31:0] word,
                                   input logic we, input logic [4:0] a3,
                                   input logic [1:0] ws, input logic [2:0] lt);
        m_slot_t m;
        m.valid = v; m.pc = pc; m.alu = alu; m.word = word;
        m.we = we; m.a3 = a3; m.wb_sel = ws; m.ld_type = lt;
        return m;
    endfunction

    // Monitor: W outputs are presented one step after each capture edge.
    always begin
        w_exp_t e;
        @(posedge clk);
        #1;
        if (!reset && sb.size() > 0) begin
            e = sb.pop_front();
            check("rf_we",     {31'h0, rf_we},     {31'h0, e.rf_we});
            check("rf_a3",     {27'h0, rf_a3},     {27'h0, e.rf_a3});
            check("rf_wd",     rf_wd,              e.rf_wd);
            check("wpc",       wpc,                e.wpc);
            check("fwd_valid", {31'h0, fwd_valid}, {31'h0, e.fwd_valid});
            check("misalign",  {31'h0, misalign},  {31'h0, e.misalign});
            check("retired",   retired,            e.retired);
        end
    end

    localparam logic [31:0] EXT_WORD = 32'h1234_F08C;

    initial begin
        logic [31:0] ret_snap;
        int          budget;

        reset = 1'b1;
        valid_m = 1'b0; pc_m = '0; alu_m = '0; dm_rdata_m = '0;
        rf_we_m = 1'b0; a3_m = '0; wb_sel_m = '0; ld_type_m = '0;

        #2;
        check("rst_rf_we",     {31'h0, rf_we},     32'h0);
        check("rst_rf_a3",     {27'h0, rf_a3},     32'h0);
        check("rst_rf_wd",     rf_wd,              32'h0);
        check("rst_wpc",       wpc,                RST_PC);
        check("rst_fwd_valid", {31'h0, fwd_valid}, 32'h0);
        check("rst_misalign",  {31'h0, misalign},  32'h0);
        check("rst_retired",   retired,            32'h0);
        #5 reset = 1'b0;

        // lw aligned
        issue(mk(1'b1, 32'h0000_3000, 32'h10, 32'h8000_00FF, 1'b1, 5'd5, 2'd1, 3'd0));
        @(posedge clk); #2;
        check("lw_rf_wd", rf_wd, 32'h8000_00FF);
        check("lw_rf_we", {31'h0, rf_we}, 32'h1);
        check("lw_rf_a3", {27'h0, rf_a3}, 32'd5);

        // Extension cases on one word
        issue(mk(1'b1, 32'h0000_3004, 32'h20, EXT_WORD, 1'b1, 5'd1, 2'd1, 3'd1));
        @(posedge clk); #2; check("lb_off0", rf_wd, 32'hFFFF_FF8C);
        issue(mk(1'b1, 32'h0000_3008, 32'h21, EXT_WORD, 1'b1, 5'd2, 2'd1, 3'd2));
        @(posedge clk); #2; check("lbu_off1", rf_wd, 32'h0000_00F0);
        issue(mk(1'b1, 32'h0000_300C, 32'h22, EXT_WORD, 1'b1, 5'd3, 2'd1, 3'd3));
        @(posedge clk); #2; check("lh_off2", rf_wd, 32'h0000_1234);
        issue(mk(1'b1, 32'h0000_3010, 32'h24, EXT_WORD, 1'b1, 5'd4, 2'd1, 3'd4));
        @(posedge clk); #2; check("lhu_off0", rf_wd, 32'h0000_F08C);

        // jal: PC+8 into r31
        issue(mk(1'b1, 32'h0000_3004, 32'h0, 32'h0, 1'b1, 5'd31, 2'd2, 3'd0));
        @(posedge clk); #2;
        check("jal_rf_wd", rf_wd, 32'h0000_300C);
        check("jal_fwd",   {31'h0, fwd_valid}, 32'h1);

        // Misaligned lw: suppressed but retired
        issue(mk(1'b1, 32'h0000_3018, 32'h13, 32'hDEAD_BEEF, 1'b1, 5'd6, 2'd1, 3'd0));
        @(posedge clk); #2;
        check("lw_mis_flag", {31'h0, misalign}, 32'h1);
        check("lw_mis_we",   {31'h0, rf_we},    32'h0);
        ret_snap = retired;
        issue(mk(1'b1, 32'h0000_301C, 32'h11, 32'hCAFE_F00D, 1'b1, 5'd7, 2'd1, 3'd3));
        @(posedge clk); #2;
        check("lw_mis_retired", retired, ret_snap + 32'd1);
        check("lh_mis_flag", {31'h0, misalign}, 32'h1);
        check("lh_mis_we",   {31'h0, rf_we},    32'h0);

        // Write to r0: writes, but not forwardable
        issue(mk(1'b1, 32'h0000_3020, 32'h55, 32'h0, 1'b1, 5'd0, 2'd0, 3'd0));
        @(posedge clk); #2;
        check("r0_we",  {31'h0, rf_we},     32'h1);
        check("r0_fwd", {31'h0, fwd_valid}, 32'h0);

        // Asynchronous reset mid-cycle with a valid writing instruction in W
        issue(mk(1'b1, 32'h0000_3024, 32'h77, 32'h0, 1'b1, 5'd9, 2'd0, 3'd0));
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("arst_rf_we",   {31'h0, rf_we},     32'h0);
        check("arst_wpc",     wpc,                RST_PC);
        check("arst_retired", retired,            32'h0);
        check("arst_fwd",     {31'h0, fwd_valid}, 32'h0);
        check("arst_rf_wd",   rf_wd,              32'h0);
        #1 reset = 1'b0;
        model_retired = 32'h0;

        // Bubble that claims a write: no write, no retire
        issue(mk(1'b0, 32'h0000_3028, 32'h99, 32'h0, 1'b1, 5'd10, 2'd0, 3'd0));
        issue(mk(1'b1, 32'h0000_302C, 32'h9A, 32'h0, 1'b1, 5'd11, 2'd0, 3'd0));
        @(posedge clk); #2;
        check("bubble_retired", retired, 32'h0);

        // Randomized back-to-back traffic
        for (int i = 0; i < 400; i++) begin
            issue(mk(($urandom_range(0, 7) != 0), $urandom, $urandom, $urandom,
                     1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom)));
        end

        // Let the scoreboard drain, bounded.
        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        check("sb_drained", sb.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mw_wb_stage

// File: doc/mw_wb_stage.md
MW_WB_STAGE -- requirements
Module: mw_wb_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, value loaded into wpc on reset.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 valid_m  in  1  M-stage slot holds a real instruction (0 = bubble).
REQ-005 pc_m  in  32  PC of the M-stage instruction.
REQ-006 alu_m  in  32  ALU result; bits [1:0] are the load byte offset.
REQ-007 dm_rdata_m  in  32  raw aligned data-memory word.
REQ-008 rf_we_m  in  1  instruction writes a GPR.
REQ-009 a3_m  in  5  destination GPR index.
REQ-010 wb_sel_m  in  2  write-back source: 0 ALU, 1 memory, 2 PC+8, 3 reserved (treated as ALU).
REQ-011 ld_type_m  in  3  0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; 5-7 treated as lw.
REQ-012 rf_we  out  1  register-file write enable.
REQ-013 rf_a3  out  5  register-file write index.
REQ-014 rf_wd  out  32  register-file write data.
REQ-015 wpc  out  32  PC of the W-stage instruction, for the write trace.
REQ-016 fwd_valid  out  1  rf_wd is forwardable to D/E: rf_we=1 and rf_a3!=0.
REQ-017 misalign  out  1  W-stage load was misaligned; write suppressed.
REQ-018 retired  out  32  count of valid instructions that have left W.

Function
REQ-019 Each posedge without reset SHALL capture all M inputs into W registers; latency M->W is exactly one cycle, with no stall input.
REQ-020 rf_wd SHALL be computed combinationally from the W registers, so the value is stable for the whole W cycle before the RF posedge write.
REQ-021 wb_sel 0/3: rf_wd = alu; 2: rf_wd = pc + 8, modulo 2^32.
REQ-022 wb_sel 1, lw: rf_wd = word.
REQ-023 wb_sel 1, lb/lbu: rf_wd = byte[8*off +: 8], sign- or zero-extended to 32 bits.
REQ-024 wb_sel 1, lh/lhu: rf_wd = half[16*off[1] +: 16], sign- or zero-extended to 32 bits.
REQ-025 Misalignment SHALL be flagged as lw with off!=0, or lh/lhu with off[0]=1, when wb_sel=1.
REQ-026 A misaligned load SHALL set misalign=1 and force rf_we=0 for that W cycle; all other outputs are unaffected.
REQ-027 rf_we = valid_w & rf_we_w & ~misalign; a bubble (valid_w=0) SHALL never write.
REQ-028 A write to index 0 SHALL still drive rf_we=1; fwd_valid SHALL be 0 for it. The RF discards index-0 writes.
REQ-029 retired SHALL increment by 1 on each posedge where valid_w=1, misaligned loads included.
REQ-030 retired SHALL wrap from 32'hFFFF_FFFF to 0 without a flag.
REQ-031 Back-to-back instructions SHALL each occupy W for exactly one cycle with no coupling between them.

Reset
REQ-032 Asserting reset SHALL immediately clear these outputs to 0: valid_w, rf_we, rf_a3, rf_wd source registers, misalign, retired, fwd_valid.
REQ-033 Asserting reset SHALL set wpc to RESET_PC.
REQ-034 Reset asserted mid-instruction SHALL drop that instruction with no write and no retired increment.
REQ-035 On the first posedge after reset deasserts, W SHALL capture the M inputs normally.

Structure
REQ-036 wb_sel and ld_type encodings and RESET_PC SHALL live in the shared pipeline package used by the D/E/M stages.
REQ-037 The load extender SHALL be one combinational sub-module, load_ext (word, offset, ld_type -> data, misalign).
REQ-038 All sequential logic SHALL stay in mw_wb_stage.

Verification
REQ-039 lw: alu_m=32'h10, dm_rdata_m=32'h8000_00FF, a3_m=5 -> next cycle rf_we=1, rf_a3=5, rf_wd=32'h8000_00FF.
REQ-040 Extension on word 32'h1234_F08C: lb off=0 -> 32'hFFFF_FF8C; lbu off=1 -> 32'h0000_00F0; lh off=2 -> 32'h0000_1234; lhu off=0 -> 32'h0000_F08C.
REQ-041 jal: wb_sel=2, pc_m=32'h0000_3004, a3_m=31 -> rf_wd=32'h0000_300C, fwd_valid=1.
REQ-042 lw with alu_m=32'h13 -> misalign=1, rf_we=0, retired increments.
REQ-043 lh with alu_m=32'h11 -> misalign=1, rf_we=0.
REQ-044 Reset pulsed asynchronously between edges with valid_w=1 -> rf_we drops immediately, wpc=32'h0000_3000, retired=0; bubble with rf_we_m=1 -> rf_we=0, retired unchanged.
